gpr_multiport: RTL
==================

// Module: gpr_multiport
// PURPOSE
//   Parametrised general-purpose register file for the single-cycle/pipelined MIPS core.
//   Provides NREAD combinational read ports and two write ports: WP0 for the main datapath, WP1 for link/flag writes (jal/bgezal -> r31, slt-style flag -> r30).
//   Adds optional write-through bypass and a per-register busy scoreboard for multi-cycle producers (loads, mul/div).
//   r0 is hardwired to zero.
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//   NREAD    2   number of read ports (1..4)
//   BYPASS   1   1: a read of an address written this cycle returns the write data; 0: returns the old value
// PORTS
//   clk        in   1               rising-edge clock
//   reset      in   1               asynchronous, active-low reset
//   rd_addr    in   NREAD*ADDR_W    packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    out  NREAD*DATA_W    packed read data, port i at [i*DATA_W +: DATA_W]
//   rd_busy    out  NREAD           1 = addressed register has a pending producer
//   wr0_en     in   1               WP0 write enable (main datapath)
//   wr0_addr   in   ADDR_W          WP0 address
//   wr0_data   in   DATA_W          WP0 data
//   wr1_en     in   1               WP1 write enable (link/flag)
//   wr1_addr   in   ADDR_W          WP1 address
//   wr1_data   in   DATA_W          WP1 data
//   sb_set     in   1               mark sb_addr busy (producer issued)
//   sb_addr    in   ADDR_W          scoreboard set address
//   sb_flush   in   1               clear all busy bits (pipeline flush)
//   wr_conflict out 1               registered pulse: WP0 and WP1 hit the same nonzero address last cycle
// BEHAVIOUR
//   Reset (reset==0, async): all registers = 0, all busy bits = 0, wr_conflict = 0. rd_data reads 0, rd_busy 0.
//   Reads: combinational, zero latency. rd_addr==0 -> data 0, busy 0 regardless of state.
//   Writes: committed on the rising clk edge when the port's enable is 1 and its address != 0. Writes to r0 are silently dropped.
//   Same-address collision (both enables, equal nonzero addr): WP0 wins, WP1 dropped; wr_conflict=1 for the following cycle only.
//   BYPASS=1: if a read address matches an enabled, nonzero write address this cycle, rd_data = that write data (WP0 priority on collision).
//   BYPASS=1: rd_busy = 0 for that port, since the write completes the producer.
//   BYPASS=0: rd_data/rd_busy reflect the stored state only.
//   Scoreboard, at each clk edge, in priority order:
//     - sb_flush: all busy bits -> 0; sb_set ignored that cycle.
//     - sb_set and sb_addr!=0: busy[sb_addr] -> 1. Set wins over a same-cycle write clear to that address (new producer).
//     - enabled write on either port: busy[wr_addr] -> 0.
//   sb_set to r0 is ignored.
//   Reset asserted mid-operation overrides everything immediately; in-flight writes are lost.
//   Deassertion takes effect at the next clk edge.
// STRUCTURE
//   Package gpr_pkg: DATA_W/ADDR_W defaults, LINK_REG=31, FLAG_REG=30, ZERO_REG=0 constants. No typedefs beyond these.
//   Sub-module gpr_scoreboard: DEPTH busy bits, set/clear/flush logic, NREAD busy lookups.
//   Storage array, write arbitration and bypass muxes stay in gpr_multiport.
// TESTING
//   1. Reset low mid-run after writing r5=0xDEAD_BEEF -> rd_data for r5 = 0 immediately; busy = 0; wr_conflict = 0.
//   2. wr0 r0=0x1234; read r0 next cycle -> 0.
//      wr0 r7=0xA5A5_0001 with rd_addr0=7 same cycle -> 0xA5A5_0001 (BYPASS=1) / old value 0 (BYPASS=0).
//   3. wr0 r31=0x11, wr1 r31=0x22 same cycle -> r31=0x11 next cycle; wr_conflict=1 for exactly one cycle.
//      wr1 r30=1, wr0 r8=3 -> both stored, no conflict.
//   4. sb_set r9 -> rd_busy for r9 = 1 next cycle. wr0 r9=0x55 -> busy 0 after edge (same-cycle read busy=0 with BYPASS).
//      sb_set r9 plus wr0 r9 same cycle -> busy stays 1.
//   5. sb_set r3, r4, r5 over three cycles, then sb_flush plus sb_set r6 same cycle -> all busy 0, including r6.
//   6. NREAD=4, DATA_W=64: write distinct values to r1..r4, read all four ports in one cycle -> each returns its own 64-bit value.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants for the MIPS general-purpose register file and its scoreboard.
package gpr_pkg;
  localparam int GPR_DATA_W = 32;
  localparam int GPR_ADDR_W = 5;
  localparam int LINK_REG   = 31;
  localparam int FLAG_REG   = 30;
  localparam int ZERO_REG   = 0;
endpackage

// File: rtl/gpr_scoreboard.sv
// Per-register busy bits tracking outstanding multi-cycle producers (loads, mul/div).
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NREAD  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_set,
  input  logic [ADDR_W-1:0]       i_set_addr,
  input  logic                    i_flush,
  input  logic                    i_clr0,
  input  logic [ADDR_W-1:0]       i_clr0_addr,
  input  logic                    i_clr1,
  input  logic [ADDR_W-1:0]       i_clr1_addr,
  input  logic [NREAD*ADDR_W-1:0] i_rd_addr,
  output logic [NREAD-1:0]        o_rd_busy
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_nxt;

  // Later assignments take priority: a new producer beats a completing write, flush beats all.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr0) w_busy_nxt[i_clr0_addr] = 1'b0;
    if (i_clr1) w_busy_nxt[i_clr1_addr] = 1'b0;
    if (i_set)  w_busy_nxt[i_set_addr]  = 1'b1;
    if (i_flush) w_busy_nxt = '0;
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_rd_busy = '0;
    for (int i = 0; i < NREAD; i++)
      o_rd_busy[i] = r_busy[i_rd_addr[i*ADDR_W +: ADDR_W]];
  end
endmodule

// File: rtl/gpr_multiport.sv
// Multi-port register file: NREAD combinational reads, two arbitrated write ports,
// optional write-through bypass and a busy scoreboard; r0 reads as zero.
module gpr_multiport
  import gpr_pkg::*;
#(
  parameter int DATA_W = GPR_DATA_W,
  parameter int ADDR_W = GPR_ADDR_W,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr0_en,
  input  logic [ADDR_W-1:0]       wr0_addr,
  input  logic [DATA_W-1:0]       wr0_data,
  input  logic                    wr1_en,
  input  logic [ADDR_W-1:0]       wr1_addr,
  input  logic [DATA_W-1:0]       wr1_data,
  input  logic                    sb_set,
  input  logic [ADDR_W-1:0]       sb_addr,
  input  logic                    sb_flush,
  output logic                    wr_conflict
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic              r_conflict;
  logic              w_we0, w_we1, w_collide;
  logic [NREAD-1:0]  w_sb_busy;
  logic [ADDR_W-1:0] w_ra;

  // WP1 loses to WP0 on an equal nonzero address.
  assign w_we0     = wr0_en && (wr0_addr != ADDR_W'(ZERO_REG));
  assign w_collide = w_we0 && wr1_en && (wr1_addr == wr0_addr);
  assign w_we1     = wr1_en && (wr1_addr != ADDR_W'(ZERO_REG)) && !w_collide;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) r_regs[k] <= '0;
      r_conflict <= 1'b0;
    end else begin
      if (w_we0) r_regs[wr0_addr] <= wr0_data;
      if (w_we1) r_regs[wr1_addr] <= wr1_data;
      r_conflict <= w_collide;
    end
  end

  assign wr_conflict = r_conflict;

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_set       (sb_set && (sb_addr != ADDR_W'(ZERO_REG))),
    .i_set_addr  (sb_addr),
    .i_flush     (sb_flush),
    .i_clr0      (wr0_en),
    .i_clr0_addr (wr0_addr),
    .i_clr1      (wr1_en),
    .i_clr1_addr (wr1_addr),
    .i_rd_addr   (rd_addr),
    .o_rd_busy   (w_sb_busy)
  );

  // A bypassed read sees the completing write, so its producer is no longer pending.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    w_ra    = '0;
    for (int i = 0; i < NREAD; i++) begin
      w_ra = rd_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = r_regs[w_ra];
      rd_busy[i] = w_sb_busy[i];
      if (BYPASS != 0 && reset) begin
        if (w_we0 && wr0_addr == w_ra) begin
          rd_data[i*DATA_W +: DATA_W] = wr0_data;
          rd_busy[i] = 1'b0;
        end else if (w_we1 && wr1_addr == w_ra) begin
          rd_data[i*DATA_W +: DATA_W] = wr1_data;
          rd_busy[i] = 1'b0;
        end
      end
      if (w_ra == ADDR_W'(ZERO_REG)) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i] = 1'b0;
      end
    end
  end
endmodule
